// File: rtl/lfsr_msg_decrypter.sv
//-----------------------------------------------------------------------------
// Module   : lfsr_msg_decrypter
// Purpose  : Recovers the LFSR tap and seed from the all-space preamble in
//            DM[IN_BASE..], then writes the decoded ASCII message to DM[OUT_BASE..].
//            Define PARITY_CHECK_EN to replace bytes that fail the parity check with 0x80.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module lfsr_msg_decrypter #(
  parameter int IN_BASE   = 64,
  parameter int OUT_BASE  = 0,
  parameter int MSG_LEN   = 64,
  parameter int CHECK_LEN = 9
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [3:0] ptrn_idx,
  output logic       ptrn_found,
  output logic [6:0] err_count
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_seed    = 3'd1;
  localparam logic [2:0] c_st_search  = 3'd2;
  localparam logic [2:0] c_st_pick    = 3'd3;
  localparam logic [2:0] c_st_decrypt = 3'd4;
  localparam logic [2:0] c_st_done    = 3'd5;

  localparam logic [7:0] c_in_base    = 8'(IN_BASE);
  localparam logic [7:0] c_out_base   = 8'(OUT_BASE);
  localparam logic [7:0] c_check_last = 8'(CHECK_LEN);
  localparam logic [7:0] c_msg_last   = 8'(MSG_LEN - 1);

  function automatic logic [6:0] f_tap(input logic [3:0] idx);
    case (idx)
      4'd0:    f_tap = 7'h60;
      4'd1:    f_tap = 7'h48;
      4'd2:    f_tap = 7'h78;
      4'd3:    f_tap = 7'h72;
      4'd4:    f_tap = 7'h6A;
      4'd5:    f_tap = 7'h69;
      4'd6:    f_tap = 7'h5C;
      4'd7:    f_tap = 7'h7E;
      4'd8:    f_tap = 7'h7B;
      default: f_tap = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] f_step(input logic [6:0] s, input logic [6:0] tap);
    f_step = {s[5:0], ^(s & tap)};
  endfunction

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic [6:0] r_prev;
  logic [6:0] r_seed;
  logic [6:0] r_lfsr;
  logic [8:0] r_mask;
  logic [3:0] r_ptrn_idx;
  logic       r_ptrn_found;
  logic [6:0] r_err_count;

  logic [6:0] w_rd7;
  logic [8:0] w_mask_next;
  logic [3:0] w_pick_idx;
  logic [7:0] w_plain;
  logic [7:0] w_dec_byte;
  logic       w_par_bad;

  assign w_rd7   = rd_data[6:0];
  assign w_plain = {1'b0, w_rd7 ^ r_lfsr} + 8'h20;

`ifdef PARITY_CHECK_EN
  assign w_par_bad  = rd_data[7] ^ (^w_rd7);
  assign w_dec_byte = w_par_bad ? 8'h80 : w_plain;
`else
  logic w_unused_par;
  assign w_par_bad    = 1'b0;
  assign w_unused_par = rd_data[7] ^ w_par_bad;
  assign w_dec_byte   = w_plain;
`endif

  // A candidate survives only if its step reproduces every observed transition.
  for (genvar k = 0; k < 9; k++) begin : g_cand
    assign w_mask_next[k] = r_mask[k] & (f_step(r_prev, f_tap(4'(k))) == w_rd7);
  end

  always_comb begin
    w_pick_idx = 4'hF;
    for (int k = 8; k >= 0; k--) begin
      if (r_mask[k]) w_pick_idx = 4'(k);
    end
  end

  always_comb begin
    rd_addr = c_in_base;
    wr_addr = c_out_base;
    wr_data = 8'h00;
    wr_en   = 1'b0;
    if (r_state == c_st_seed || r_state == c_st_search || r_state == c_st_decrypt) begin
      rd_addr = c_in_base + r_cnt;
    end
    if (r_state == c_st_decrypt) begin
      // Reset must suppress the write committed on the same edge.
      wr_en   = ~Reset;
      wr_addr = c_out_base + r_cnt;
      wr_data = w_dec_byte;
    end
  end

  assign Ack        = (r_state == c_st_done);
  assign ptrn_idx   = r_ptrn_idx;
  assign ptrn_found = r_ptrn_found;
  assign err_count  = r_err_count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= c_st_idle;
      r_cnt        <= 8'd0;
      r_prev       <= 7'd0;
      r_seed       <= 7'd0;
      r_lfsr       <= 7'd0;
      r_mask       <= 9'h1FF;
      r_ptrn_idx   <= 4'hF;
      r_ptrn_found <= 1'b0;
      r_err_count  <= 7'd0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (!Start) begin
            r_state      <= c_st_seed;
            r_cnt        <= 8'd0;
            r_mask       <= 9'h1FF;
            r_ptrn_found <= 1'b0;
            r_err_count  <= 7'd0;
          end
        end
        c_st_seed: begin
          r_prev <= w_rd7;
          r_seed <= w_rd7;
          if (w_rd7 == 7'd0) begin
            r_state <= c_st_done;
          end else begin
            r_state <= c_st_search;
            r_cnt   <= 8'd1;
          end
        end
        c_st_search: begin
          r_mask <= w_mask_next;
          r_prev <= w_rd7;
          if (r_cnt == c_check_last) r_state <= c_st_pick;
          else                       r_cnt   <= r_cnt + 8'd1;
        end
        c_st_pick: begin
          r_ptrn_idx   <= w_pick_idx;
          r_ptrn_found <= |r_mask;
          if (r_mask == 9'd0) begin
            r_state <= c_st_done;
          end else begin
            r_state <= c_st_decrypt;
            r_lfsr  <= r_seed;
            r_cnt   <= 8'd0;
          end
        end
        c_st_decrypt: begin
          r_lfsr <= f_step(r_lfsr, f_tap(r_ptrn_idx));
          if (w_par_bad) r_err_count <= r_err_count + 7'd1;
          if (r_cnt == c_msg_last) r_state <= c_st_done;
          else                     r_cnt   <= r_cnt + 8'd1;
        end
        c_st_done: begin
          if (Start) r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule

`default_nettype wire
